logic_proc_sequencer: RTL and testbench

- Control and serial-compute front end that drives the two-register shift unit (reg A / reg B pair).
- Issues load strobes and a burst of exactly WIDTH shift enables.
- Consumes the serial bits shifted out of A and B, applies a selected bitwise function, and returns the routed result bits to the registers' serial inputs.
- Sits between the switch/button interface and the register unit of the logic processor.

---
 rtl/logic_proc_pkg.sv | 48 ++++
 rtl/serial_alu.sv | 36 +++
 rtl/logic_proc_sequencer.sv | 99 +++++++++
 tb/tb_logic_proc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_proc_pkg.sv
// Shared types and the bitwise function table for the logic processor
// sequencer and its serial ALU.
package logic_proc_pkg;

  // Sequencer states: wait for a request, run the shift burst, wait for release.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Function select codes; the upper bit inverts the lower four.
  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_XOR  = 3'b010,
    F_ONE  = 3'b011,
    F_NAND = 3'b100,
    F_NOR  = 3'b101,
    F_XNOR = 3'b110,
    F_ZERO = 3'b111
  } func_t;

  // Result routing: which register receives the function output.
  typedef enum logic [1:0] {
    R_ROTATE = 2'b00,  // both registers rotate unchanged
    R_B_FUNC = 2'b01,  // A rotates, B takes f
    R_A_FUNC = 2'b10,  // A takes f, B rotates
    R_SWAP   = 2'b11   // A and B exchange contents
  } route_t;

  // One bit of the selected bitwise function.
  function automatic logic apply_func(func_t f, logic a, logic b);
    logic res;
    case (f)
      F_AND:   res = a & b;
      F_OR:    res = a | b;
      F_XOR:   res = a ^ b;
      F_ONE:   res = 1'b1;
      F_NAND:  res = ~(a & b);
      F_NOR:   res = ~(a | b);
      F_XNOR:  res = ~(a ^ b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_alu.sv
// Combinational serial ALU: takes the bits leaving reg A and reg B, applies
// the latched function and routes the result back to the registers' MSBs.
module serial_alu
  import logic_proc_pkg::*;
(
  input  logic   a_out_i,
  input  logic   b_out_i,
  input  func_t  f_i,
  input  route_t r_i,
  output logic   a_in_o,
  output logic   b_in_o
);

  logic f_bit;

  assign f_bit = apply_func(f_i, a_out_i, b_out_i);

  // Route the function bit or the raw serial bits back into the registers.
  always_comb begin
    a_in_o = a_out_i;
    b_in_o = b_out_i;
    case (r_i)
      R_B_FUNC: b_in_o = f_bit;
      R_A_FUNC: a_in_o = f_bit;
      R_SWAP: begin
        a_in_o = b_out_i;
        b_in_o = a_out_i;
      end
      default: begin
        a_in_o = a_out_i;
        b_in_o = b_out_i;
      end
    endcase
  end

endmodule

// File: rtl/logic_proc_sequencer.sv
// Sequencer for the two-register shift unit: passes load strobes through
// while idle, runs exactly WIDTH shift cycles per Execute request and feeds
// the serial ALU result back into the registers during the burst.
module logic_proc_sequencer
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_out,
  input  logic       B_out,
  output logic       Shift_En,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       A_In,
  output logic       B_In,
  output logic       Busy,
  output logic       Done
);

  localparam int WIDTH_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH_CW-1:0] LAST_CNT = WIDTH_CW'(WIDTH - 1);
  localparam logic [WIDTH_CW-1:0] CNT_ONE  = WIDTH_CW'(1);

  state_t              state_q;
  logic [WIDTH_CW-1:0] cnt_q;
  func_t               f_q;
  route_t              r_q;
  logic                done_q;
  logic                alu_a_in;
  logic                alu_b_in;

  // Control FSM: latches F/R at start, counts the burst, pulses Done after it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f_q     <= F_AND;
      r_q     <= R_ROTATE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Execute) begin
            f_q     <= func_t'(F);
            r_q     <= route_t'(R);
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Counter saturates at WIDTH-1 so it never wraps.
          if (cnt_q == LAST_CNT) begin
            state_q <= HOLD;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          // A held Execute parks here so it cannot trigger a second run.
          if (!Execute) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  serial_alu u_serial_alu (
    .a_out_i (A_out),
    .b_out_i (B_out),
    .f_i     (f_q),
    .r_i     (r_q),
    .a_in_o  (alu_a_in),
    .b_in_o  (alu_b_in)
  );

  // The strobes and serial bits are combinational paths, so they are gated
  // with Reset to keep every output low while reset is held.
  assign Shift_En = Reset & (state_q == SHIFT);
  assign Ld_A     = Reset & (state_q == IDLE) & LoadA;
  assign Ld_B     = Reset & (state_q == IDLE) & LoadB;
  assign A_In     = Reset & alu_a_in;
  assign B_In     = Reset & alu_b_in;
  assign Busy     = Reset & (state_q != IDLE);
  assign Done     = done_q;

endmodule

// File: tb/tb_logic_proc_sequencer.sv
// Bench for logic_proc_sequencer: models the two-register shift unit around
// the DUT, predicts each operation's final register contents with whole-word
// arithmetic and checks them when Done pulses.
module tb_logic_proc_sequencer;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         execute = 1'b0;
  logic         load_a = 1'b0;
  logic         load_b = 1'b0;
  logic [2:0]   f = 3'd0;
  logic [1:0]   r = 2'd0;
  logic [W-1:0] d_sw = '0;
  logic [W-1:0] ra = '0;
  logic [W-1:0] rb = '0;

  logic shift_en, ld_a, ld_b, a_in, b_in, busy, done;

  int errors = 0;
  int checks = 0;
  int shift_cnt = 0;
  int busy_total = 0;
  int done_total = 0;
  int ld_viol = 0;
  int txn = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  logic_proc_sequencer #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .Execute  (execute),
    .LoadA    (load_a),
    .LoadB    (load_b),
    .F        (f),
    .R        (r),
    .A_out    (ra[0]),
    .B_out    (rb[0]),
    .Shift_En (shift_en),
    .Ld_A     (ld_a),
    .Ld_B     (ld_b),
    .A_In     (a_in),
    .B_In     (b_in),
    .Busy     (busy),
    .Done     (done)
  );

  // Register unit: parallel load from the switches, or shift right with MSB in.
  always @(posedge clk) begin
    if (ld_a) ra <= d_sw;
    else if (shift_en) ra <= {a_in, ra[W-1:1]};
    if (ld_b) rb <= d_sw;
    else if (shift_en) rb <= {b_in, rb[W-1:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word function then routing of the result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] fs, input logic [1:0] rs);
    logic [W-1:0] fv;
    exp_t e;
    case (fs)
      3'd0: fv = a & b;
      3'd1: fv = a | b;
      3'd2: fv = a ^ b;
      3'd3: fv = '1;
      3'd4: fv = ~(a & b);
      3'd5: fv = ~(a | b);
      3'd6: fv = ~(a ^ b);
      default: fv = '0;
    endcase
    case (rs)
      2'd0: begin e.a = a;  e.b = b;  end
      2'd1: begin e.a = a;  e.b = fv; end
      2'd2: begin e.a = fv; e.b = b;  end
      default: begin e.a = b; e.b = a; end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts shift/busy cycles and scores the registers on each Done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        shift_cnt = 0;
      end else begin
        if (shift_en) shift_cnt++;
        if (busy) busy_total++;
        if (busy && (ld_a || ld_b)) ld_viol++;
        if (done) begin
          done_total++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got Done=1, expected no operation pending");
          end else begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d: A=0x%02h (exp 0x%02h) B=0x%02h (exp 0x%02h) shifts=%0d",
                     txn, ra, e.a, rb, e.b, shift_cnt);
            chk("result_a", 32'(ra), 32'(e.a));
            chk("result_b", 32'(rb), 32'(e.b));
            chk("shift_cycles", shift_cnt, W);
          end
          shift_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got Busy=1 after 200 cycles, expected 0");
    end
  endtask

  // One operation: load A and B, hold Execute for 'hold' sampled edges,
  // optionally disturb loads and F/R while shifting.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] fs, input logic [1:0] rs,
                        input int hold, input bit disturb);
    int busy0, done0, viol0, exp_busy;
    load_a = 1'b1; d_sw = a; tick();
    load_a = 1'b0; load_b = 1'b1; d_sw = b; tick();
    load_b = 1'b0;
    busy0 = busy_total; done0 = done_total; viol0 = ld_viol;
    exp_q.push_back(model(a, b, fs, rs));
    execute = 1'b1; f = fs; r = rs;
    tick();
    for (int i = 1; i < hold; i++) begin
      if (disturb && i == 2) begin
        load_a = 1'b1; d_sw = '0; f = ~fs; r = ~rs;
      end
      tick();
    end
    execute = 1'b0; load_a = 1'b0;
    wait_idle();
    exp_busy = (hold > W + 1) ? hold : W + 1;
    chk("busy_cycles", busy_total - busy0, exp_busy);
    chk("done_pulses", done_total - done0, 1);
    chk("loads_blocked", ld_viol - viol0, 0);
  endtask

  initial begin
    int n;
    // Reset held with requests active: everything must stay low.
    load_a = 1'b1; load_b = 1'b1; execute = 1'b1;
    #12;
    chk("reset_outputs", {shift_en, ld_a, ld_b, a_in, b_in, busy, done}, 0);
    load_a = 1'b0; load_b = 1'b0; execute = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {busy, done, shift_en}, 0);

    run_op(8'h5A, 8'h3C, 3'b010, 2'b01, 1, 1'b0);
    run_op(8'h5A, 8'h3C, 3'b011, 2'b10, 1, 1'b0);
    run_op(8'h5A, 8'h3C, 3'b000, 2'b11, 1, 1'b0);
    run_op(8'hA5, 8'h0F, 3'b110, 2'b00, 5, 1'b0);
    run_op(8'hA5, 8'h0F, 3'b001, 2'b00, 14, 1'b0);
    run_op(8'h5A, 8'h3C, 3'b010, 2'b01, 30, 1'b0);
    run_op(8'hA5, 8'h0F, 3'b010, 2'b10, 12, 1'b1);
    run_op(8'hC3, 8'h96, 3'b100, 2'b01, 4, 1'b1);

    // Reset in the middle of a burst aborts asynchronously.
    load_a = 1'b1; d_sw = 8'hE7; tick();
    load_a = 1'b0; load_b = 1'b1; d_sw = 8'h18; tick();
    load_b = 1'b0;
    execute = 1'b1; f = 3'b010; r = 2'b11;
    tick();
    n = 0;
    while (shift_cnt < 4 && n < 50) begin
      tick();
      n++;
    end
    chk("reached_shift4", shift_cnt >= 4, 1);
    rst_n = 1'b0; load_a = 1'b1;
    #1;
    chk("abort_outputs", {shift_en, ld_a, ld_b, a_in, b_in, busy, done}, 0);
    tick();
    tick();
    chk("abort_held", {shift_en, ld_a, busy, done}, 0);
    rst_n = 1'b1; load_a = 1'b0; execute = 1'b0;
    tick();
    chk("abort_idle", {busy, done}, 0);
    run_op(8'h5A, 8'h3C, 3'b010, 2'b01, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom), 2'($urandom),
             $urandom_range(1, 14), 1'($urandom));
    end

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
